// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and default core configuration.
package fetch_stage_pkg;

    localparam int unsigned XLEN_CFG       = 64;
    localparam int unsigned REG_ADDR_WIDTH = 10;
    localparam int unsigned INST_WIDTH     = 32;

    typedef struct packed {
        logic [XLEN_CFG-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FETCH_BOOT,
        FETCH_RUN,
        FETCH_FAULT
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} fetch entries with flush.
module fetch_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rptr_q];
    // Push while full is accepted only when the head leaves the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, ram lane select, fetch buffer and redirect handling.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_CFG,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [XLEN-1:0]       imem_rdata,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [XLEN-1:0]       inst_pc
);
    localparam int unsigned S = $clog2(XLEN / 8);

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [INST_WIDTH-1:0] inst;
    } entry_t;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     sel;
    logic            fetch, fifo_pop, full, empty;
    entry_t          wdata, rdata;

    assign imem_addr = pc_q[ADDR_WIDTH+S-1:S];

    if (XLEN == 32) begin : g_lane32
        assign sel = imem_rdata[31:0];
    end else begin : g_lane64
        assign sel = pc_q[2] ? imem_rdata[63:32] : imem_rdata[31:0];
    end

    assign wdata    = '{pc: pc_q, inst: sel};
    assign fifo_pop = !empty && inst_ready && !redirect_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic            fault_pend_q, fault_pend_d;
    logic            misaligned;

    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fetch   = 1'b0;
        if (redirect_valid) begin
            state_d = FETCH_RUN;
            pc_d    = redirect_pc & ~XLEN'(3);
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
                state_d = FETCH_FAULT;
            end
`endif
        end else begin
            case (state_q)
                FETCH_BOOT: state_d = FETCH_RUN;
                FETCH_RUN: begin
                    if (!full || fifo_pop) begin
                        fetch = 1'b1;
                        pc_d  = pc_q + XLEN'(4);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_comb begin
        fault_pc_d   = fault_pc_q;
        fault_pend_d = fault_pend_q;
        if (redirect_valid) begin
            fault_pc_d   = redirect_pc;
            fault_pend_d = misaligned;
        end else if (state_q == FETCH_FAULT && inst_ready) begin
            fault_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_pc_q   <= '0;
            fault_pend_q <= 1'b0;
        end else begin
            fault_pc_q   <= fault_pc_d;
            fault_pend_q <= fault_pend_d;
        end
    end

    // The trap entry is presented outside the FIFO, which is empty while faulted.
    always_comb begin
        inst_valid = !empty;
        inst       = rdata.inst;
        inst_pc    = rdata.pc;
        if (state_q == FETCH_FAULT) begin
            inst_valid = fault_pend_q;
            inst       = 32'h0;
            inst_pc    = fault_pc_q;
        end
    end
`else
    always_comb begin
        inst_valid = !empty;
        inst       = rdata.inst;
        inst_pc    = rdata.pc;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_BOOT;
            pc_q    <= XLEN'(RESET_PC);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(redirect_valid),
        .push (fetch),
        .pop  (fifo_pop),
        .wdata(wdata),
        .rdata(rdata),
        .full (full),
        .empty(empty)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (default config, XLEN = 64).
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  imem_addr;
    logic [63:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    logic [63:0] ram [1024];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = ram[imem_addr];

    fetch_stage u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = ready;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 64'h0 || imem_addr !== 10'h0) begin
            errors++;
            $display("FAIL reset_state got v=%b i=%h pc=%h a=%h want 0/0/0/0",
                     inst_valid, inst, inst_pc, imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_idle got v=%b want 0", inst_valid);
        end
        step();
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'hAAAA_AAAA || inst_pc !== 64'h0) begin
            errors++;
            $display("FAIL first_inst got v=%b i=%h pc=%h want 1/aaaaaaaa/0", inst_valid, inst, inst_pc);
        end
        step();
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'hBBBB_BBBB || inst_pc !== 64'h4) begin
            errors++;
            $display("FAIL second_inst got v=%b i=%h pc=%h want 1/bbbbbbbb/4", inst_valid, inst, inst_pc);
        end
        step();
        checks++;
        if (inst !== 32'hC0DE_0008 || inst_pc !== 64'h8) begin
            errors++;
            $display("FAIL third_inst got i=%h pc=%h want c0de0008/8", inst, inst_pc);
        end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        repeat (10) step();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h0 || imem_addr !== 10'h1) begin
            errors++;
            $display("FAIL stall_full got v=%b pc=%h a=%h want 1/0/1", inst_valid, inst_pc, imem_addr);
        end
        inst_ready = 1'b1;
        step();
        checks++;
        if (inst_pc !== 64'h4 || inst !== 32'hBBBB_BBBB) begin
            errors++;
            $display("FAIL drain_1 got pc=%h i=%h want 4/bbbbbbbb", inst_pc, inst);
        end
        step();
        checks++;
        if (inst_pc !== 64'h8 || inst !== 32'hC0DE_0008 || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_2 got v=%b pc=%h i=%h want 1/8/c0de0008", inst_valid, inst_pc, inst);
        end
        step();
        checks++;
        if (inst_pc !== 64'hC) begin
            errors++;
            $display("FAIL drain_3 got pc=%h want c", inst_pc);
        end
    endtask

    task automatic test_redirect_full();
        do_reset(1'b0);
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_addr !== 10'h8) begin
            errors++;
            $display("FAIL redir_flush got v=%b a=%h want 0/8", inst_valid, imem_addr);
        end
        step();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h40 || inst !== 32'hC0DE_0040) begin
            errors++;
            $display("FAIL redir_target got v=%b pc=%h i=%h want 1/40/c0de0040", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_redirect_pop();
        do_reset(1'b1);
        repeat (3) step();
        checks++;
        if (inst_pc !== 64'h4) begin
            errors++;
            $display("FAIL pre_pop got pc=%h want 4", inst_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_redir_flush got v=%b want 0", inst_valid);
        end
        step();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h80 || inst !== 32'hC0DE_0080) begin
            errors++;
            $display("FAIL pop_redir_tgt got v=%b pc=%h i=%h want 1/80/c0de0080", inst_valid, inst_pc, inst);
        end
        step();
        checks++;
        if (inst_pc !== 64'h84 || inst !== 32'hC0DE_0084) begin
            errors++;
            $display("FAIL pop_redir_next got pc=%h i=%h want 84/c0de0084", inst_pc, inst);
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (imem_addr !== 10'h3FF || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_alias got a=%h v=%b want 3ff/0", imem_addr, inst_valid);
        end
        step();
        checks++;
        if (inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC || inst !== 32'hC0DE_1FFC || imem_addr !== 10'h0) begin
            errors++;
            $display("FAIL wrap_top got pc=%h i=%h a=%h want fffffffffffffffc/c0de1ffc/0",
                     inst_pc, inst, imem_addr);
        end
        step();
        checks++;
        if (inst_pc !== 64'h0 || inst !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL wrap_zero got pc=%h i=%h want 0/aaaaaaaa", inst_pc, inst);
        end
    endtask

    task automatic test_misalign();
        do_reset(1'b0);
        repeat (2) step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h42;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0 || inst_pc !== 64'h42) begin
            errors++;
            $display("FAIL trap_entry got v=%b i=%h pc=%h want 1/0/42", inst_valid, inst, inst_pc);
        end
        inst_ready = 1'b1;
        step();
        step();
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL trap_no_fetch got v=%b want 0", inst_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h44;
        step();
        redirect_valid = 1'b0;
        step();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h44 || inst !== 32'hC0DE_0044) begin
            errors++;
            $display("FAIL trap_resume got v=%b pc=%h i=%h want 1/44/c0de0044", inst_valid, inst_pc, inst);
        end
`else
        checks++;
        if (inst_valid !== 1'b0 || imem_addr !== 10'h8) begin
            errors++;
            $display("FAIL misalign_flush got v=%b a=%h want 0/8", inst_valid, imem_addr);
        end
        step();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h40 || inst !== 32'hC0DE_0040) begin
            errors++;
            $display("FAIL misalign_clear got v=%b pc=%h i=%h want 1/40/c0de0040", inst_valid, inst_pc, inst);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || imem_addr !== 10'h0) begin
            errors++;
            $display("FAIL async_reset got v=%b a=%h want 0/0", inst_valid, imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            ram[i] = {16'hC0DE, 3'b000, 13'(i * 8 + 4), 16'hC0DE, 3'b000, 13'(i * 8)};
        end
        ram[0] = 64'hBBBB_BBBB_AAAA_AAAA;

        test_reset();
        test_stall();
        test_redirect_full();
        test_redirect_pop();
        test_wrap();
        test_misalign();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
